// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC point-verification datapath:
// FSM states, default operand width and product-slot indices.
package ecc_pkg;

    localparam int unsigned W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MUL,
        ADD1,
        ADD2,
        DONE
    } state_e;

    localparam logic [1:0] P_YY  = 2'd0;
    localparam logic [1:0] P_XX  = 2'd1;
    localparam logic [1:0] P_XXX = 2'd2;
    localparam logic [1:0] P_AX  = 2'd3;

endpackage

// File: rtl/ecc_modmul_serial.sv
// Bit-serial MSB-first interleaved modular multiplier: W cycles per product.
// The first step happens on the edge that samples i_start; o_done follows the last step.
module ecc_modmul_serial
    import ecc_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_multiplicand,
    input  logic [W-1:0] i_multiplier,
    input  logic [W-1:0] i_p,
    output logic [W-1:0] o_result,
    output logic         o_done
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]  mplier_q, mplier_d;
    logic [W-1:0]  p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic          done_q, done_d;

    logic [W-1:0]  op_acc, op_mcand, op_mplier, op_p;
    logic [W+1:0]  dbl, sum;

    always_comb begin
        op_acc    = i_start ? '0 : acc_q;
        op_mcand  = i_start ? i_multiplicand : mcand_q;
        op_mplier = i_start ? i_multiplier : mplier_q;
        op_p      = i_start ? i_p : p_q;

        // Both reductions settle in one cycle; operands < p keep W+2 bits sufficient.
        dbl = {2'b00, op_acc} << 1;
        if (dbl >= {2'b00, op_p}) begin
            dbl = dbl - {2'b00, op_p};
        end
        sum = dbl + (op_mplier[W-1] ? {2'b00, op_mcand} : '0);
        if (sum >= {2'b00, op_p}) begin
            sum = sum - {2'b00, op_p};
        end

        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        done_d   = 1'b0;

        if (i_start) begin
            acc_d    = sum[W-1:0];
            mcand_d  = op_mcand;
            mplier_d = op_mplier << 1;
            p_d      = op_p;
            cnt_d    = CW'(W - 1);
            run_d    = (W > 1);
            done_d   = (W == 1);
        end else if (run_q) begin
            acc_d    = sum[W-1:0];
            mplier_d = op_mplier << 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            done_q   <= done_d;
        end
    end

    assign o_result = acc_q;
    assign o_done   = done_q;

endmodule

// File: rtl/ecc_point_verify.sv
// Checks that a captured point (x, y) satisfies y^2 = x^3 + a*x + b (mod p),
// flagging the point at infinity as on-curve and out-of-field operands as range errors.
module ecc_point_verify
    import ecc_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_inf,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_prime,
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_on_curve,
    output logic         o_range_err
);

    state_e       state_q, state_d;
    logic [W-1:0] x_q, x_d, y_q, y_d, a_q, a_d, b_q, b_d, p_q, p_d;
    logic         inf_q, inf_d, err_q, err_d;
    logic [W-1:0] t0_q, t0_d, t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
    logic [W-1:0] s_q, s_d;
    logic [1:0]   idx_q, idx_d;
    logic         busy_q, busy_d, done_q, done_d;
    logic         on_curve_q, on_curve_d, range_err_q, range_err_d;

    logic         range_bad;
    logic [W-1:0] s_sum;
    logic         mm_start;
    logic [W-1:0] mm_mcand, mm_mplier, mm_result;
    logic         mm_done;

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] u, input logic [W-1:0] v,
                                             input logic [W-1:0] m);
        logic [W:0] t;
        t = {1'b0, u} + {1'b0, v};
        if (t >= {1'b0, m}) begin
            t = t - {1'b0, m};
        end
        return t[W-1:0];
    endfunction

    ecc_modmul_serial #(.W(W)) u_modmul (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (mm_start),
        .i_multiplicand (mm_mcand),
        .i_multiplier   (mm_mplier),
        .i_p            (p_q),
        .o_result       (mm_result),
        .o_done         (mm_done)
    );

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        a_d         = a_q;
        b_d         = b_q;
        p_d         = p_q;
        inf_d       = inf_q;
        err_d       = err_q;
        t0_d        = t0_q;
        t1_d        = t1_q;
        t2_d        = t2_q;
        t3_d        = t3_q;
        s_d         = s_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        on_curve_d  = on_curve_q;
        range_err_d = range_err_q;
        mm_start    = 1'b0;
        mm_mcand    = '0;
        mm_mplier   = '0;
        range_bad   = (p_q < W'(2)) || (x_q >= p_q) || (y_q >= p_q) ||
                      (a_q >= p_q) || (b_q >= p_q);
        s_sum       = mod_add(s_q, b_q, p_q);

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    x_d     = i_x;
                    y_d     = i_y;
                    a_d     = i_a;
                    b_d     = i_b;
                    p_d     = i_prime;
                    inf_d   = i_inf;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                err_d = !inf_q && range_bad;
                // Short paths skip the products but still commit the verdict in ADD2;
                // y*y is launched here so the four products fill exactly 4W MUL cycles.
                if (inf_q || range_bad) begin
                    state_d = ADD2;
                end else begin
                    state_d   = MUL;
                    idx_d     = P_YY;
                    mm_start  = 1'b1;
                    mm_mcand  = y_q;
                    mm_mplier = y_q;
                end
            end
            MUL: begin
                if (mm_done) begin
                    case (idx_q)
                        P_YY:    t0_d = mm_result;
                        P_XX:    t1_d = mm_result;
                        P_XXX:   t2_d = mm_result;
                        default: t3_d = mm_result;
                    endcase
                    if (idx_q == P_AX) begin
                        state_d = ADD1;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        mm_start  = 1'b1;
                        mm_mplier = x_q;
                        case (idx_d)
                            P_XX:    mm_mcand = x_q;
                            P_XXX:   mm_mcand = mm_result;
                            default: mm_mcand = a_q;
                        endcase
                    end
                end
            end
            ADD1: begin
                s_d     = mod_add(t2_q, t3_q, p_q);
                state_d = ADD2;
            end
            ADD2: begin
                s_d     = s_sum;
                done_d  = 1'b1;
                state_d = DONE;
                if (inf_q) begin
                    on_curve_d  = 1'b1;
                    range_err_d = 1'b0;
                end else if (err_q) begin
                    on_curve_d  = 1'b0;
                    range_err_d = 1'b1;
                end else begin
                    on_curve_d  = (s_sum == t0_q);
                    range_err_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            inf_q       <= 1'b0;
            err_q       <= 1'b0;
            t0_q        <= '0;
            t1_q        <= '0;
            t2_q        <= '0;
            t3_q        <= '0;
            s_q         <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            on_curve_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            a_q         <= a_d;
            b_q         <= b_d;
            p_q         <= p_d;
            inf_q       <= inf_d;
            err_q       <= err_d;
            t0_q        <= t0_d;
            t1_q        <= t1_d;
            t2_q        <= t2_d;
            t3_q        <= t3_d;
            s_q         <= s_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            on_curve_q  <= on_curve_d;
            range_err_q <= range_err_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_on_curve  = on_curve_q;
    assign o_range_err = range_err_q;

endmodule

// File: tb/tb_ecc_point_verify.sv
// Directed plus randomized checks of ecc_point_verify against a plain-arithmetic
// model of the curve equation, field-range rules and job latency.
module tb_ecc_point_verify;

    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b0;
    logic         i_start = 1'b0;
    logic         i_inf = 1'b0;
    logic [W-1:0] i_a = '0, i_b = '0, i_prime = '0, i_x = '0, i_y = '0;
    logic         o_busy, o_done, o_on_curve, o_range_err;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_accept = 0;

    ecc_point_verify #(.W(W)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_inf       (i_inf),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_prime     (i_prime),
        .i_x         (i_x),
        .i_y         (i_y),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_on_curve  (o_on_curve),
        .o_range_err (o_range_err)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference: verdict straight from the curve equation, latency from the job length.
    task automatic model(input logic inf, input int a, input int b, input int p,
                         input int x, input int y,
                         output logic on, output logic err, output int lat);
        if (inf) begin
            on = 1'b1; err = 1'b0; lat = 2;
        end else if (p < 2 || x >= p || y >= p || a >= p || b >= p) begin
            on = 1'b0; err = 1'b1; lat = 2;
        end else begin
            on  = ((y * y) % p) == ((x * x * x + a * x + b) % p);
            err = 1'b0;
            lat = 4 * W + 3;
        end
    endtask

    task automatic run_job(input string tag, input logic inf, input int a, input int b,
                           input int p, input int x, input int y);
        logic exp_on, exp_err;
        int   exp_lat, lat;
        model(inf, a, b, p, x, y, exp_on, exp_err, exp_lat);
        check({tag, "/idle"}, o_busy, 0);
        i_inf = inf; i_a = W'(a); i_b = W'(b); i_prime = W'(p); i_x = W'(x); i_y = W'(y);
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        last_accept = cyc;
        i_start = 1'b0;
        i_inf = $urandom_range(0, 1); i_a = W'($urandom); i_b = W'($urandom);
        i_prime = W'($urandom); i_x = W'($urandom); i_y = W'($urandom);
        check({tag, "/busy_after_accept"}, o_busy, 1);
        lat = -1;
        for (int k = 1; k <= 100 && lat < 0; k++) begin
            @(posedge i_clk);
            #1;
            if (o_done) lat = k;
        end
        check({tag, "/latency"}, lat, exp_lat);
        if (lat >= 0) begin
            check({tag, "/on_curve"}, o_on_curve, exp_on);
            check({tag, "/range_err"}, o_range_err, exp_err);
            check({tag, "/busy_at_done"}, o_busy, 1);
            @(posedge i_clk);
            #1;
            check({tag, "/done_width"}, o_done, 0);
            check({tag, "/busy_release"}, o_busy, 0);
            check({tag, "/verdict_hold"}, o_on_curve, exp_on);
        end
    endtask

    initial begin
        int first_accept, dones;
        int p, a, b, x, y, r;
        logic inf;

        repeat (2) @(posedge i_clk);
        #1;
        check("reset/busy", o_busy, 0);
        check("reset/done", o_done, 0);
        check("reset/on_curve", o_on_curve, 0);
        check("reset/range_err", o_range_err, 0);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;

        run_job("p11_on", 1'b0, 1, 6, 11, 2, 4);
        run_job("p11_off", 1'b0, 1, 6, 11, 2, 5);
        run_job("p97_on", 1'b0, 2, 3, 97, 3, 6);
        first_accept = last_accept;
        run_job("p97_off_b2b", 1'b0, 2, 3, 97, 3, 7);
        check("b2b_spacing", last_accept - first_accept, 4 * W + 5);
        run_job("x_eq_p", 1'b0, 1, 6, 11, 11, 4);
        run_job("p_one", 1'b0, 0, 0, 1, 0, 0);
        run_job("inf_garbage", 1'b1, 255, 255, 11, 255, 255);

        // Job aborted by reset at edge 10 with an ignored start pulse mid-MUL.
        dones = 0;
        i_inf = 1'b0; i_a = 8'd1; i_b = 8'd6; i_prime = 8'd11; i_x = 8'd2; i_y = 8'd4;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge i_clk);
            #1;
            if (o_done) dones++;
            i_start = (k == 4 || k == 5);
            i_x = 8'd7;
        end
        i_start = 1'b0;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        check("abort/busy", o_busy, 0);
        check("abort/done", o_done, 0);
        check("abort/on_curve", o_on_curve, 0);
        check("abort/range_err", o_range_err, 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge i_clk);
            #1;
            if (o_done || o_busy) dones++;
        end
        check("abort/no_done", dones, 0);
        run_job("after_abort", 1'b0, 1, 6, 11, 2, 4);

        for (int n = 0; n < 30; n++) begin
            r   = $urandom_range(0, 9);
            p   = (r == 0) ? $urandom_range(0, 1) : $urandom_range(2, 255);
            inf = ($urandom_range(0, 9) == 0);
            if (p >= 2) begin
                a = $urandom % p; b = $urandom % p; x = $urandom % p; y = $urandom % p;
                if ($urandom_range(0, 1) == 1) begin
                    for (int c = 0; c < p; c++) begin
                        if ((c * c) % p == (x * x * x + a * x + b) % p) y = c;
                    end
                end
                r = $urandom_range(0, 9);
                if (r == 0) x = $urandom_range(p, 255);
                if (r == 1) y = $urandom_range(p, 255);
                if (r == 2) a = $urandom_range(p, 255);
                if (r == 3) b = $urandom_range(p, 255);
            end else begin
                a = $urandom_range(0, 255); b = $urandom_range(0, 255);
                x = $urandom_range(0, 255); y = $urandom_range(0, 255);
            end
            run_job($sformatf("rand%0d", n), inf, a, b, p, x, y);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
